aud_i2s_tx: RTL and testbench

Stream-to-I2S transmitter at the output end of the effect chain. It accepts 16-bit signed mono samples from the last effect stage over a valid/ready stream, buffers them in a small FIFO, and serialises each sample MSB-first onto the codec DAC data line, framed by the codec-mastered DACLRCK. The same word is sent on the left and right channels. Underrun and overflow are handled deterministically and flagged.

---
 rtl/aud_pkg.sv | 8 +
 rtl/aud_sample_fifo.sv | 57 +++++
 rtl/aud_i2s_tx.sv | 138 +++++++++++++
 tb/tb_aud_i2s_tx.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/aud_pkg.sv
// Shared audio-path types: sample width, sample type and the I2S transmit FSM states.
package aud_pkg;
  localparam int AUD_DATA_W = 16;

  typedef enum logic [1:0] {TX_IDLE, TX_SHIFT, TX_PAD} tx_state_t;

  typedef logic signed [AUD_DATA_W-1:0] aud_sample_t;
endpackage

// File: rtl/aud_sample_fifo.sv
// Small synchronous sample FIFO with flush; the head word is visible combinationally on rd_data.
module aud_sample_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_reg == CW'(DEPTH));
  assign empty   = (count_reg == '0);
  // A push into a full FIFO is legal only when the head leaves in the same cycle.
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && (!full || do_pop) && !flush;
  assign rd_data = mem[rd_ptr_reg];
  assign count   = count_reg;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_reg + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/aud_i2s_tx.sv
// Stream-to-I2S transmitter: buffers mono samples and sends each word MSB-first on both
// channel slots of a codec-mastered DACLRCK, with deterministic underrun/overflow handling.
module aud_i2s_tx
  import aud_pkg::*;
#(
  parameter int DATA_W      = AUD_DATA_W,
  parameter int FIFO_DEPTH  = 4,
  parameter bit LEFT_ON_LOW = 1'b1
) (
  input  logic                        i_AUD_BCLK,
  input  logic                        i_rst_n,
  input  logic                        i_daclrck,
  input  logic                        i_en,
  input  logic                        i_mute,
  input  logic                        i_valid,
  input  logic [DATA_W-1:0]           i_data,
  output logic                        o_ready,
  output logic                        o_dacdat,
  output logic [$clog2(FIFO_DEPTH):0] o_fill,
  output logic                        o_underrun,
  output logic                        o_overflow
);

  localparam int   CW       = $clog2(FIFO_DEPTH) + 1;
  localparam int   CNT_W    = $clog2(DATA_W + 1);
  localparam logic LEFT_LVL = LEFT_ON_LOW ? 1'b0 : 1'b1;

  tx_state_t         state_reg, state_next;
  logic [DATA_W-1:0] shift_reg, shift_next;
  logic [DATA_W-1:0] hold_reg, hold_next;
  logic [CNT_W-1:0]  bit_cnt_reg, bit_cnt_next;
  logic              dacdat_reg, dacdat_next;
  logic              underrun_reg, underrun_next;
  logic              overflow_reg, overflow_next;
  logic              lrck_q;
  logic              en_reg;

  logic              lrck_edge, left_start, right_start;
  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [DATA_W-1:0] fifo_head, load_word;
  logic [CW-1:0]     fifo_count;

  aud_sample_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (i_AUD_BCLK),
    .rst_n   (i_rst_n),
    .flush   (!i_en),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .wr_data (i_data),
    .rd_data (fifo_head),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_comb begin
    lrck_edge     = (i_daclrck != lrck_q);
    left_start    = lrck_edge && (i_daclrck == LEFT_LVL);
    right_start   = lrck_edge && (i_daclrck != LEFT_LVL);
    fifo_pop      = i_en && left_start && !fifo_empty;
    fifo_push     = i_en && i_valid && (!fifo_full || fifo_pop);
    underrun_next = i_en && left_start && fifo_empty;
    overflow_next = i_en && i_valid && fifo_full && !fifo_pop;
    // An empty pop repeats the previous word; mute only replaces what is shifted out.
    load_word     = i_mute ? '0 : (fifo_pop ? fifo_head : hold_reg);

    state_next   = state_reg;
    shift_next   = shift_reg;
    bit_cnt_next = bit_cnt_reg;
    dacdat_next  = dacdat_reg;
    hold_next    = fifo_pop ? fifo_head : hold_reg;

    if (!i_en) begin
      state_next   = TX_IDLE;
      dacdat_next  = 1'b0;
      bit_cnt_next = '0;
    end else if (left_start || (right_start && state_reg != TX_IDLE)) begin
      // Any accepted edge restarts the slot, aborting a word cut short by a short frame.
      state_next   = TX_SHIFT;
      dacdat_next  = load_word[DATA_W-1];
      shift_next   = {load_word[DATA_W-2:0], 1'b0};
      bit_cnt_next = CNT_W'(1);
    end else begin
      unique case (state_reg)
        TX_IDLE: dacdat_next = 1'b0;
        TX_SHIFT: begin
          if (bit_cnt_reg == CNT_W'(DATA_W)) begin
            state_next  = TX_PAD;
            dacdat_next = 1'b0;
          end else begin
            dacdat_next  = shift_reg[DATA_W-1];
            shift_next   = {shift_reg[DATA_W-2:0], 1'b0};
            bit_cnt_next = bit_cnt_reg + CNT_W'(1);
          end
        end
        TX_PAD:  dacdat_next = 1'b0;
        default: begin
          state_next  = TX_IDLE;
          dacdat_next = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge i_AUD_BCLK or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg    <= TX_IDLE;
      shift_reg    <= '0;
      hold_reg     <= '0;
      bit_cnt_reg  <= '0;
      dacdat_reg   <= 1'b0;
      underrun_reg <= 1'b0;
      overflow_reg <= 1'b0;
      lrck_q       <= 1'b0;
      en_reg       <= 1'b1;
    end else begin
      state_reg    <= state_next;
      shift_reg    <= shift_next;
      hold_reg     <= hold_next;
      bit_cnt_reg  <= bit_cnt_next;
      dacdat_reg   <= dacdat_next;
      underrun_reg <= underrun_next;
      overflow_reg <= overflow_next;
      lrck_q       <= i_daclrck;
      en_reg       <= i_en;
    end
  end

  assign o_ready    = en_reg && !fifo_full;
  assign o_dacdat   = dacdat_reg;
  assign o_fill     = fifo_count;
  assign o_underrun = underrun_reg;
  assign o_overflow = overflow_reg;

endmodule

// File: tb/tb_aud_i2s_tx.sv
// Directed self-checking bench for aud_i2s_tx: framing, FIFO limits, underrun, mute, enable and short slots.
module tb_aud_i2s_tx;
  localparam int DW = 16;
  localparam int FD = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          daclrck = 1'b1;
  logic          en = 1'b1;
  logic          mute = 1'b0;
  logic          valid = 1'b0;
  logic [DW-1:0] data = '0;
  logic          ready, dacdat, underrun, overflow;
  logic [2:0]    fill;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  aud_i2s_tx #(
    .DATA_W      (DW),
    .FIFO_DEPTH  (FD),
    .LEFT_ON_LOW (1'b1)
  ) dut (
    .i_AUD_BCLK (clk),
    .i_rst_n    (rst_n),
    .i_daclrck  (daclrck),
    .i_en       (en),
    .i_mute     (mute),
    .i_valid    (valid),
    .i_data     (data),
    .o_ready    (ready),
    .o_dacdat   (dacdat),
    .o_fill     (fill),
    .o_underrun (underrun),
    .o_overflow (overflow)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("[TB] %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic push(input logic [DW-1:0] d);
    valid = 1'b1;
    data  = d;
    cyc();
    valid = 1'b0;
  endtask

  // One LRCK frame: left slot (low) then right slot (high); captures the first DW bits of each slot.
  task automatic frame(input int slot, output logic [DW-1:0] lw, output logic [DW-1:0] rw,
                       output int pad, output int und, output int ovf);
    lw = '0; rw = '0; pad = 0; und = 0; ovf = 0;
    for (int s = 0; s < 2; s++) begin
      daclrck = (s == 0) ? 1'b0 : 1'b1;
      for (int i = 0; i < slot; i++) begin
        cyc();
        if (i < DW) begin
          if (s == 0) lw = {lw[DW-2:0], dacdat};
          else        rw = {rw[DW-2:0], dacdat};
        end else if (dacdat !== 1'b0) begin
          pad++;
        end
        if (underrun) und++;
        if (overflow) ovf++;
      end
    end
  endtask

  task automatic frame_chk(input string tag, input int slot, input logic [DW-1:0] exp_w, input int exp_und);
    logic [DW-1:0] lw, rw;
    int pad, und, ovf;
    frame(slot, lw, rw, pad, und, ovf);
    check({tag, "_left"},  32'(lw), 32'(exp_w));
    check({tag, "_right"}, 32'(rw), 32'(exp_w));
    check({tag, "_pad"},   32'(pad), 32'd0);
    check({tag, "_und"},   32'(und), 32'(exp_und));
    check({tag, "_ovf"},   32'(ovf), 32'd0);
  endtask

  logic [DW-1:0] q2 [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
  int silent;

  initial begin
    // Reset
    #2 rst_n = 1'b0;
    repeat (3) cyc();
    check("rst_dacdat",   32'(dacdat),   32'd0);
    check("rst_fill",     32'(fill),     32'd0);
    check("rst_ready",    32'(ready),    32'd1);
    check("rst_underrun", 32'(underrun), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    rst_n = 1'b1;
    repeat (2) cyc();

    // Basic framing with one word
    push(16'hA5C3);
    check("t1_fill_in", 32'(fill), 32'd1);
    frame_chk("t1", 32, 16'hA5C3, 0);
    check("t1_fill_out", 32'(fill), 32'd0);

    // Fill to capacity, then overflow
    for (int i = 0; i < 4; i++) push(q2[i]);
    check("t2_fill_full", 32'(fill),  32'd4);
    check("t2_ready_low", 32'(ready), 32'd0);
    valid = 1'b1; data = 16'h5555;
    cyc();
    valid = 1'b0;
    check("t2_ovf_pulse", 32'(overflow), 32'd1);
    check("t2_fill_kept", 32'(fill),     32'd4);
    cyc();
    check("t2_ovf_end",   32'(overflow), 32'd0);
    for (int i = 0; i < 4; i++) frame_chk($sformatf("t2_f%0d", i), 32, q2[i], 0);
    check("t2_fill_out", 32'(fill), 32'd0);

    // Underrun repeats the last word
    push(16'h7FFF);
    frame_chk("t3_f0", 32, 16'h7FFF, 0);
    frame_chk("t3_f1", 32, 16'h7FFF, 1);
    frame_chk("t3_f2", 32, 16'h7FFF, 1);

    // Mute
    mute = 1'b1;
    push(16'h8001);
    check("t4_fill_a", 32'(fill), 32'd1);
    frame_chk("t4_mute", 32, 16'h0000, 0);
    check("t4_fill_b", 32'(fill), 32'd0);
    mute = 1'b0;
    push(16'h1234);
    check("t4_fill_c", 32'(fill), 32'd1);
    frame_chk("t4_unmute", 32, 16'h1234, 0);
    check("t4_fill_d", 32'(fill), 32'd0);

    // Disable mid-word, re-enable in the right slot
    push(16'hAAAA); push(16'hBBBB); push(16'hCCCC);
    daclrck = 1'b0;
    repeat (5) cyc();
    check("t5_fill_pop", 32'(fill), 32'd2);
    en = 1'b0;
    cyc();
    check("t5_dis_fill",   32'(fill),   32'd0);
    check("t5_dis_dacdat", 32'(dacdat), 32'd0);
    check("t5_dis_ready",  32'(ready),  32'd0);
    push(16'hEEEE);
    check("t5_dis_ovf",  32'(overflow), 32'd0);
    check("t5_dis_fill2", 32'(fill),    32'd0);
    silent = 0;
    repeat (20) begin cyc(); if (dacdat !== 1'b0) silent++; end
    daclrck = 1'b1;
    en = 1'b1;
    for (int i = 0; i < 32; i++) begin
      valid = (i == 5);
      data  = 16'hDDDD;
      cyc();
      if (dacdat !== 1'b0) silent++;
    end
    valid = 1'b0;
    check("t5_silent",   32'(silent), 32'd0);
    check("t5_ready_re", 32'(ready),  32'd1);
    check("t5_fill_re",  32'(fill),   32'd1);
    frame_chk("t5_resume", 32, 16'hDDDD, 0);

    // Short 10-BCLK slots truncate each word to its top 10 bits
    push(16'hA5C3);
    push(16'h3C5A);
    frame_chk("t6_a", 10, 16'h0297, 0);
    frame_chk("t6_b", 10, 16'h00F1, 0);
    check("t6_fill", 32'(fill), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
